// File: rtl/instr_queue_mw.sv
// Multi-lane instruction queue between decode and issue.
// Up to PUSH_W entries enter per cycle and up to POP_W leave per cycle.
// The oldest POP_W entries are shown combinationally on pop_data.
// A front-end flush empties the queue and enters HOLD. While in HOLD,
// refill pushes are accepted but pops stay blocked. A back-end flush
// empties the queue and returns to RUN.
//
// Handshake contract:
//  - Push: the whole group in push_valid (contiguous from lane 0) is
//    taken at the edge when push_ready=1 and no flush is asserted.
//    Otherwise it is dropped, and the source must hold its data.
//  - Pop: pop_valid lanes are contiguous from lane 0. The consumer takes
//    pop_cnt entries at the edge, where pop_cnt <= popcount(pop_valid).
//    pop_cnt is clamped to that limit.
module instr_queue_mw #(
  parameter int DW     = 64,
  parameter int AW     = 3,
  parameter int PUSH_W = 2,
  parameter int POP_W  = 2
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic [PUSH_W-1:0]          push_valid,
  input  logic [PUSH_W*DW-1:0]       push_data,
  output logic                       push_ready,
  output logic [POP_W-1:0]           pop_valid,
  output logic [POP_W*DW-1:0]        pop_data,
  input  logic [$clog2(POP_W+1)-1:0] pop_cnt,
  input  logic                       feflush,
  input  logic                       beflush,
  output logic                       hold,
  output logic [AW:0]                count
);

  localparam int DEPTH = 1 << AW;
  localparam int PCW   = $clog2(POP_W + 1);
  localparam int NPW   = $clog2(PUSH_W + 1);

  typedef enum logic {RUN = 1'b0, HOLD = 1'b1} state_t;

  state_t            state, state_next;
  logic [DW-1:0]     mem [DEPTH];
  logic [AW:0]       rd_ptr, wr_ptr;
  logic [AW+1:0]     free_slots;
  logic [NPW-1:0]    n_push;
  logic [PCW-1:0]    n_avail;
  logic [PCW-1:0]    pop_eff;
  logic              flush;
  logic              push_acc;

  // Occupancy comes from the pointers. The extra MSB tells full from empty.
  assign count      = wr_ptr - rd_ptr;
  assign free_slots = (AW+2)'(DEPTH) - (AW+2)'(count);
  // The ready check ignores any same-cycle pop, so it depends only on registered state.
  assign push_ready = free_slots >= (AW+2)'(PUSH_W);
  assign flush      = feflush | beflush;
  assign push_acc   = push_ready & ~flush;
  assign hold       = (state == HOLD);
  assign pop_eff    = (pop_cnt > n_avail) ? n_avail : pop_cnt;

  // Lane counts, head visibility and the zero-latency head read.
  always_comb begin
    n_push    = '0;
    n_avail   = '0;
    pop_valid = '0;
    pop_data  = '0;
    for (int i = 0; i < PUSH_W; i++) begin
      n_push = n_push + NPW'(push_valid[i]);
    end
    for (int i = 0; i < POP_W; i++) begin
      pop_valid[i]         = (count > (AW+1)'(i)) && (state == RUN);
      n_avail              = n_avail + PCW'(pop_valid[i]);
      pop_data[i*DW +: DW] = mem[rd_ptr[AW-1:0] + AW'(i)];
    end
  end

  // Mispredict-hold next-state logic. beflush takes priority over feflush.
  always_comb begin
    state_next = state;
    if (beflush) begin
      state_next = RUN;
    end else if (feflush && state == RUN) begin
      state_next = HOLD;
    end
  end

  // State and pointer registers. A flush drops the queue contents by moving rd_ptr up to wr_ptr.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state  <= RUN;
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else begin
      state <= state_next;
      if (flush) begin
        rd_ptr <= wr_ptr;
      end else begin
        rd_ptr <= rd_ptr + (AW+1)'(pop_eff);
        if (push_acc) begin
          wr_ptr <= wr_ptr + (AW+1)'(n_push);
        end
      end
    end
  end

  // Entry storage. It is not reset, and it is written only for accepted push lanes.
  always_ff @(posedge CLK) begin
    if (!RST && push_acc) begin
      for (int i = 0; i < PUSH_W; i++) begin
        if (push_valid[i]) begin
          mem[wr_ptr[AW-1:0] + AW'(i)] <= push_data[i*DW +: DW];
        end
      end
    end
  end

endmodule

// File: tb/tb_instr_queue_mw.sv
// Directed bench for instr_queue_mw with its default parameters
// (DW=64, DEPTH=8, PUSH_W=2, POP_W=2).
module tb_instr_queue_mw;

  localparam int DW = 64;

  logic            clk = 1'b0;
  logic            rst;
  logic [1:0]      push_valid;
  logic [2*DW-1:0] push_data;
  logic            push_ready;
  logic [1:0]      pop_valid;
  logic [2*DW-1:0] pop_data;
  logic [1:0]      pop_cnt;
  logic            feflush;
  logic            beflush;
  logic            hold;
  logic [3:0]      count;

  int n_checks = 0;
  int n_fail   = 0;

  logic [DW-1:0] exp_q[$];

  typedef struct {
    logic          rst;
    logic [1:0]    pv;
    logic [DW-1:0] d0, d1;
    logic [1:0]    pc;
    logic          fe, be;
    logic [3:0]    e_count;
    logic          e_pr;
    logic [1:0]    e_pv;
    logic          e_hold;
    logic [DW-1:0] e0, e1;
  } vec_t;

  vec_t vq[$];

  instr_queue_mw dut (
    .CLK        (clk),
    .RST        (rst),
    .push_valid (push_valid),
    .push_data  (push_data),
    .push_ready (push_ready),
    .pop_valid  (pop_valid),
    .pop_data   (pop_data),
    .pop_cnt    (pop_cnt),
    .feflush    (feflush),
    .beflush    (beflush),
    .hold       (hold),
    .count      (count)
  );

  // Clock and reset
  always #5 clk = ~clk;

  // Stimulus legality checks, sampled at the edge
  always @(posedge clk) begin
    if (!rst) begin
      assert ((push_valid & (push_valid + 2'd1)) == 2'b00)
        else $error("push_valid not contiguous: %b", push_valid);
      assert (32'(pop_cnt) <= 32'(pop_valid[0]) + 32'(pop_valid[1]))
        else $error("pop_cnt %0d exceeds pop_valid %b", pop_cnt, pop_valid);
    end
  end

  // Scoreboard compare
  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic void add(input logic r, input logic [1:0] pv, input logic [DW-1:0] d0,
                              input logic [DW-1:0] d1, input logic [1:0] pc, input logic fe,
                              input logic be, input logic [3:0] ec, input logic epr,
                              input logic [1:0] epv, input logic eh, input logic [DW-1:0] e0,
                              input logic [DW-1:0] e1);
    vec_t v;
    v.rst = r; v.pv = pv; v.d0 = d0; v.d1 = d1; v.pc = pc; v.fe = fe; v.be = be;
    v.e_count = ec; v.e_pr = epr; v.e_pv = epv; v.e_hold = eh; v.e0 = e0; v.e1 = e1;
    vq.push_back(v);
  endfunction

  // Driver: present one cycle of inputs
  task automatic drive(input logic r, input logic [1:0] pv, input logic [DW-1:0] d0,
                       input logic [DW-1:0] d1, input logic [1:0] pc, input logic fe,
                       input logic be);
    rst = r; push_valid = pv; push_data = {d1, d0}; pop_cnt = pc; feflush = fe; beflush = be;
  endtask

  initial begin
    drive(1'b1, 2'b00, '0, '0, 2'd0, 1'b0, 1'b0);

    //   rst pv     d0     d1     pc fe be  cnt pr pv    hold e0     e1
    // Reset with junk on the other inputs
    add(1, 2'b11, 64'h1,  64'h2,  2, 1, 0,  0, 1, 2'b00, 0, 0,     0);
    // Two-lane push, then pop both
    add(0, 2'b11, 64'hA0, 64'hB0, 0, 0, 0,  2, 1, 2'b11, 0, 64'hA0, 64'hB0);
    add(0, 2'b00, 0,      0,      2, 0, 0,  0, 1, 2'b00, 0, 0,     0);
    // Fill to full, drop a push, pop one with a push that is also dropped
    add(0, 2'b11, 64'h1,  64'h2,  0, 0, 0,  2, 1, 2'b11, 0, 64'h1, 64'h2);
    add(0, 2'b11, 64'h3,  64'h4,  0, 0, 0,  4, 1, 2'b11, 0, 64'h1, 64'h2);
    add(0, 2'b11, 64'h5,  64'h6,  0, 0, 0,  6, 1, 2'b11, 0, 64'h1, 64'h2);
    add(0, 2'b11, 64'h7,  64'h8,  0, 0, 0,  8, 0, 2'b11, 0, 64'h1, 64'h2);
    add(0, 2'b11, 64'h9,  64'hA,  0, 0, 0,  8, 0, 2'b11, 0, 64'h1, 64'h2);
    add(0, 2'b11, 64'hB,  64'hC,  1, 0, 0,  7, 0, 2'b11, 0, 64'h2, 64'h3);
    add(0, 2'b00, 0,      0,      0, 0, 0,  7, 0, 2'b11, 0, 64'h2, 64'h3);
    add(0, 2'b00, 0,      0,      2, 0, 0,  5, 1, 2'b11, 0, 64'h4, 64'h5);
    add(0, 2'b00, 0,      0,      2, 0, 0,  3, 1, 2'b11, 0, 64'h6, 64'h7);
    add(0, 2'b00, 0,      0,      2, 0, 0,  1, 1, 2'b01, 0, 64'h8, 0);
    add(0, 2'b00, 0,      0,      1, 0, 0,  0, 1, 2'b00, 0, 0,     0);
    // Front-end flush with 3 queued, refill in HOLD, release by beflush
    add(0, 2'b11, 64'h21, 64'h22, 0, 0, 0,  2, 1, 2'b11, 0, 64'h21, 64'h22);
    add(0, 2'b01, 64'h23, 0,      0, 0, 0,  3, 1, 2'b11, 0, 64'h21, 64'h22);
    add(0, 2'b11, 64'h24, 64'h25, 0, 1, 0,  0, 1, 2'b00, 1, 0,     0);
    add(0, 2'b11, 64'h31, 64'h32, 0, 0, 0,  2, 1, 2'b00, 1, 0,     0);
    add(0, 2'b00, 0,      0,      0, 0, 1,  0, 1, 2'b00, 0, 0,     0);
    // Repeated feflush while in HOLD keeps HOLD
    add(0, 2'b11, 64'h41, 64'h42, 0, 1, 0,  0, 1, 2'b00, 1, 0,     0);
    add(0, 2'b11, 64'h43, 64'h44, 0, 0, 0,  2, 1, 2'b00, 1, 0,     0);
    add(0, 2'b00, 0,      0,      0, 1, 0,  0, 1, 2'b00, 1, 0,     0);
    // Both flushes together, from HOLD and from RUN
    add(0, 2'b11, 64'h51, 64'h52, 0, 1, 1,  0, 1, 2'b00, 0, 0,     0);
    add(0, 2'b11, 64'h61, 64'h62, 0, 0, 0,  2, 1, 2'b11, 0, 64'h61, 64'h62);
    add(0, 2'b11, 64'h63, 64'h64, 2, 1, 1,  0, 1, 2'b00, 0, 0,     0);
    // Reach count=5 in HOLD, then assert reset mid-stream
    add(0, 2'b00, 0,      0,      0, 1, 0,  0, 1, 2'b00, 1, 0,     0);
    add(0, 2'b11, 64'h71, 64'h72, 0, 0, 0,  2, 1, 2'b00, 1, 0,     0);
    add(0, 2'b11, 64'h73, 64'h74, 0, 0, 0,  4, 1, 2'b00, 1, 0,     0);
    add(0, 2'b01, 64'h75, 0,      0, 0, 0,  5, 1, 2'b00, 1, 0,     0);
    add(1, 2'b11, 64'h76, 64'h77, 0, 1, 0,  0, 1, 2'b00, 0, 0,     0);
    // Normal operation right after reset, including a simultaneous push and pop
    add(0, 2'b11, 64'h81, 64'h82, 0, 0, 0,  2, 1, 2'b11, 0, 64'h81, 64'h82);
    add(0, 2'b01, 64'h83, 0,      1, 0, 0,  2, 1, 2'b11, 0, 64'h82, 64'h83);
    add(0, 2'b00, 0,      0,      2, 0, 0,  0, 1, 2'b00, 0, 0,     0);

    foreach (vq[k]) begin
      drive(vq[k].rst, vq[k].pv, vq[k].d0, vq[k].d1, vq[k].pc, vq[k].fe, vq[k].be);
      @(posedge clk);
      #1;
      check($sformatf("v%0d count", k), DW'(count), DW'(vq[k].e_count));
      check($sformatf("v%0d push_ready", k), DW'(push_ready), DW'(vq[k].e_pr));
      check($sformatf("v%0d pop_valid", k), DW'(pop_valid), DW'(vq[k].e_pv));
      check($sformatf("v%0d hold", k), DW'(hold), DW'(vq[k].e_hold));
      if (vq[k].e_pv[0]) check($sformatf("v%0d pop_data0", k), pop_data[DW-1:0], vq[k].e0);
      if (vq[k].e_pv[1]) check($sformatf("v%0d pop_data1", k), pop_data[2*DW-1:DW], vq[k].e1);
    end

    // Wrap-around streaming: push 2 and pop 2 each cycle with incrementing data
    for (int c = 0; c < 20; c++) begin
      logic [DW-1:0] a, b;
      a = DW'(64'h1000 + 2 * c);
      b = a + 1;
      if (c > 0) begin
        check($sformatf("wrap%0d pop_valid", c), DW'(pop_valid), DW'(2'b11));
        if (exp_q.size() >= 2) begin
          check($sformatf("wrap%0d lane0", c), pop_data[DW-1:0], exp_q.pop_front());
          check($sformatf("wrap%0d lane1", c), pop_data[2*DW-1:DW], exp_q.pop_front());
        end
        drive(1'b0, 2'b11, a, b, 2'd2, 1'b0, 1'b0);
      end else begin
        drive(1'b0, 2'b11, a, b, 2'd0, 1'b0, 1'b0);
      end
      exp_q.push_back(a);
      exp_q.push_back(b);
      @(posedge clk);
      #1;
      check($sformatf("wrap%0d count", c), DW'(count), DW'(2));
    end
    // Drain the last pair
    check("wrap_drain lane0", pop_data[DW-1:0], exp_q.pop_front());
    check("wrap_drain lane1", pop_data[2*DW-1:DW], exp_q.pop_front());
    drive(1'b0, 2'b00, '0, '0, 2'd2, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    check("wrap_drain count", DW'(count), DW'(0));
    check("wrap_drain queue", DW'(exp_q.size()), DW'(0));
    drive(1'b0, 2'b00, '0, '0, 2'd0, 1'b0, 1'b0);
    @(posedge clk);
    #1;

    // Final report
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/instr_queue_mw.md
Name: instr_queue_mw

Overview:
- Parametrised multi-width instruction queue between the front end (decode output) and the back end (issue).
- Successor to the single-lane, 2-entry decode FIFO, with a configurable number of push lanes, pop lanes and depth.
- Folds in the mispredict-hold tracking: after a front-end flush, pops stay blocked until the back end flushes.

Parameters:
- DW, 64, width of one decoded micro-instruction entry.
- AW, 3, log2 of queue depth (DEPTH = 2^AW). Requires DEPTH >= PUSH_W and DEPTH >= POP_W.
- PUSH_W, 2, push lanes per cycle.
- POP_W, 2, pop lanes per cycle.

Ports:
- CLK  in  1  clock; all state updates on rising edge.
- RST  in  1  synchronous reset, active-high.
- push_valid  in  PUSH_W  per-lane push request; must be contiguous from lane 0.
- push_data  in  PUSH_W*DW  lane i occupies bits [i*DW +: DW].
- push_ready  out  1  whole push group may be accepted this cycle.
- pop_valid  out  POP_W  per-lane entry available; always contiguous from lane 0.
- pop_data  out  POP_W*DW  lane i = i-th oldest entry.
- pop_cnt  in  $clog2(POP_W+1)  number of entries consumed this cycle.
- feflush  in  1  front-end flush (mispredict redirect).
- beflush  in  1  back-end flush (trap/privileged redirect).
- hold  out  1  mispredict-hold state; pops are blocked while high.
- count  out  AW+1  current occupancy.

Behaviour:
- Storage is DEPTH x DW, not reset.
- Pointers: rd_ptr and wr_ptr, each AW+1 bits. Index is the low AW bits. Pointers wrap modulo 2^(AW+1).
- count = wr_ptr - rd_ptr, (AW+1)-bit modular arithmetic.
- Reset (RST=1 at a clock edge, including mid-operation):
  - rd_ptr = wr_ptr = 0, state = RUN, count = 0.
  - push_ready = 1, pop_valid = 0, hold = 0.
  - All other inputs are ignored that cycle.
- push_ready = (DEPTH - count) >= PUSH_W. Combinational from registered count. Deliberately does not credit a same-cycle pop.
- Push:
  - Accepted when push_ready and no flush this cycle.
  - n_push = popcount(push_valid). Lane i is written at index (wr_ptr+i) mod DEPTH.
  - wr_ptr advances by n_push.
  - If push_ready = 0, the push is dropped; the source must hold its data.
  - Non-contiguous push_valid is illegal and flagged by a bench assertion.
- pop_valid[i] = (count > i) & (state == RUN).
- pop_data lane i = mem[(rd_ptr+i) mod DEPTH]. Combinational read, zero-latency view of the head.
- Pop:
  - rd_ptr advances by pop_cnt at the edge.
  - pop_cnt greater than popcount(pop_valid) is illegal (bench assertion). RTL clamps pop_cnt to popcount(pop_valid).
- Simultaneous push and pop: count_next = count + n_push - pop_cnt. Both take effect in the same edge.
- State machine, two states (RUN, HOLD):
  - RUN -> HOLD on feflush & ~beflush.
  - Any state -> RUN on beflush.
  - HOLD stays HOLD otherwise, including on a repeated feflush.
  - hold = (state == HOLD), registered output.
- Flush (feflush | beflush):
  - Queue emptied at the edge: rd_ptr <= wr_ptr.
  - Same-cycle push and pop are discarded.
  - push_ready next cycle = 1.
- In HOLD:
  - Pushes are accepted normally (correct-path refill).
  - pop_valid = 0 and pop_cnt is ignored.
  - Entries become visible the cycle after HOLD exits, unless that exit is a beflush, which empties the queue.
- Latency: a push at edge k is visible on pop_valid from cycle k+1 (state RUN).
- count and pointers must stay consistent across wrap. A full queue (count = DEPTH) is distinguished from empty by pointer MSB.

Test Plan:
- Reset then push two lanes A,B (PUSH_W=2) -> next cycle pop_valid=2'b11, pop_data={B,A}, count=2. pop_cnt=2 -> count=0, pop_valid=0.
- Push 4 groups of 2 without popping (DEPTH=8) -> count=8, push_ready=0. A 5th push is dropped and count stays 8. Pop 1 with a simultaneous push -> push dropped, count=7. Next cycle push_ready=0 still (free=1 < 2).
- Wrap-around: 20 cycles of push 2 / pop 2 with incrementing data -> data pops strictly in order, with no loss or duplication across pointer wrap. count stays 2 after warm-up.
- feflush with 3 entries queued -> next cycle count=0, hold=1. Push 2 entries -> count=2, pop_valid=0. Assert beflush -> hold=0, count=0.
- feflush and beflush in the same cycle with a push -> state RUN, hold=0, count=0, push discarded.
- RST asserted mid-stream (count=5, state HOLD) -> next cycle count=0, hold=0, push_ready=1, pop_valid=0. Normal push/pop resumes immediately.
